// File: rtl/imm_field_encoder.sv
// imm_field_encoder: finds an immediate-extender encoding for a 32-bit value, trying one candidate class per cycle
module imm_field_encoder #(
  parameter int ALLOW_BRANCH = 1,
  parameter int FAIL_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_value,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [23:0]           out_data,
  output logic [1:0]            out_control,
  output logic                  out_ok,
  output logic [FAIL_CNT_W-1:0] fail_count
);
  typedef enum logic [1:0] {IDLE, TRY, DONE} state_t;
  state_t                  state_q;
  logic [31:0]             val_q;
  logic                    auto_q;
  logic [1:0]              cand_q;
  logic                    in_ready_q, out_valid_q, out_ok_q;
  logic [23:0]             out_data_q;
  logic [1:0]              out_ctrl_q;
  logic [FAIL_CNT_W-1:0]   fail_q;
  logic                    br, sgn_ok, fit, last;
  logic [23:0]             data_d;

  assign br = ALLOW_BRANCH != 0;

  // fit test and encoded field for the current candidate class
  always_comb begin
    sgn_ok = val_q[31:24] == 8'h00 || val_q[31:24] == 8'hFF;
    fit    = cand_q == 2'd0 ? val_q[31:8] == 24'h0 :
             cand_q == 2'd1 ? val_q[31:12] == 20'h0 :
             cand_q == 2'd2 ? br && sgn_ok && val_q[1:0] == 2'b00 : 1'b0;
    data_d = cand_q == 2'd0 ? {16'h0, val_q[7:0]} :
             cand_q == 2'd1 ? {12'h0, val_q[11:0]} :
                              {val_q[31], val_q[31], val_q[23:2]};
    last   = !auto_q || cand_q == 2'd2 || (cand_q == 2'd1 && !br);
  end

  // request capture, candidate walk, result hold and failure counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      val_q       <= '0;
      auto_q      <= 1'b0;
      cand_q      <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= 2'd0;
      out_ok_q    <= 1'b0;
      fail_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          val_q      <= in_value;
          auto_q     <= in_mode == 2'd3;
          cand_q     <= in_mode == 2'd3 ? 2'd0 : in_mode;
          in_ready_q <= 1'b0;
          state_q    <= TRY;
        end
        TRY: if (fit || last) begin
          out_data_q  <= fit ? data_d : 24'h0;
          out_ctrl_q  <= cand_q;
          out_ok_q    <= fit;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end else begin
          cand_q <= cand_q + 2'd1;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
          if (!out_ok_q && fail_q != '1) fail_q <= fail_q + FAIL_CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_control = out_ctrl_q;
  assign out_ok      = out_ok_q;
  assign fail_count  = fail_q;
endmodule

// File: tb/tb_imm_field_encoder.sv
// tb_imm_field_encoder: directed vector check of the encoder with and without branch class
module tb_imm_field_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_value = '0;
  logic [1:0]  in_mode = '0;
  logic        iv_a = 1'b0, iv_b = 1'b0, or_a = 1'b0, or_b = 1'b0;
  logic        ir_a, ir_b, ov_a, ov_b, ok_a, ok_b;
  logic [23:0] od_a, od_b;
  logic [1:0]  oc_a, oc_b;
  logic [7:0]  fc_a, fc_b;
  logic        sel = 1'b0;
  logic        ir, ov, ok;
  logic [23:0] od;
  logic [1:0]  oc;
  logic [7:0]  fc;
  int          total = 0, bad = 0;
  int          fail_mdl [2];

  always #5 clk = ~clk;

  imm_field_encoder #(.ALLOW_BRANCH(1), .FAIL_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_value(in_value),
    .in_mode(in_mode), .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
    .out_control(oc_a), .out_ok(ok_a), .fail_count(fc_a));

  imm_field_encoder #(.ALLOW_BRANCH(0), .FAIL_CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_value(in_value),
    .in_mode(in_mode), .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
    .out_control(oc_b), .out_ok(ok_b), .fail_count(fc_b));

  assign ir = sel ? ir_b : ir_a;
  assign ov = sel ? ov_b : ov_a;
  assign ok = sel ? ok_b : ok_a;
  assign od = sel ? od_b : od_a;
  assign oc = sel ? oc_b : oc_a;
  assign fc = sel ? fc_b : fc_a;

  typedef struct {
    logic        s;
    logic [31:0] value;
    logic [1:0]  mode;
    int          lat;
    logic [23:0] data;
    logic [1:0]  ctrl;
    logic        ok;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_iv(input logic v);
    if (sel) iv_b = v; else iv_a = v;
  endtask

  task automatic set_or(input logic v);
    if (sel) or_b = v; else or_a = v;
  endtask

  // accept a request, then wait for out_valid and return the cycle count
  task automatic issue(input logic [31:0] v, input logic [1:0] m, output int k);
    @(negedge clk);
    in_value = v;
    in_mode  = m;
    set_iv(1'b1);
    @(posedge clk);
    #1;
    set_iv(1'b0);
    in_value = ~v;
    in_mode  = ~m;
    k = 0;
    while (!ov && k < 8) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!ov) begin
      bad++;
      total++;
      $display("FAIL timeout: out_valid never rose for value %h", v);
    end
  endtask

  task automatic handoff(input logic was_ok);
    @(negedge clk);
    set_or(1'b1);
    @(posedge clk);
    #1;
    set_or(1'b0);
    if (!was_ok && fail_mdl[sel] < 255) fail_mdl[sel]++;
    chk("out_valid_after_handoff", {31'b0, ov}, 32'd0);
    chk("in_ready_after_handoff", {31'b0, ir}, 32'd1);
    chk("fail_count", {24'b0, fc}, 32'(fail_mdl[sel]));
  endtask

  vec_t vecs [12];
  int   k;

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_00A5, 2'd0, 1, 24'h0000A5, 2'd0, 1'b1};
    vecs[1]  = '{1'b0, 32'h0000_1234, 2'd1, 1, 24'h000000, 2'd1, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0ABC, 2'd3, 2, 24'h000ABC, 2'd1, 1'b1};
    vecs[3]  = '{1'b0, 32'hFFFF_FFF8, 2'd3, 3, 24'hFFFFFE, 2'd2, 1'b1};
    vecs[4]  = '{1'b1, 32'hFFFF_FFF8, 2'd3, 2, 24'h000000, 2'd1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0100_0000, 2'd2, 1, 24'h000000, 2'd2, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0002, 2'd2, 1, 24'h000000, 2'd2, 1'b0};
    vecs[7]  = '{1'b0, 32'h00FF_FFFC, 2'd2, 1, 24'h3FFFFF, 2'd2, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0005, 2'd3, 1, 24'h000005, 2'd0, 1'b1};
    vecs[9]  = '{1'b1, 32'h0000_0008, 2'd2, 1, 24'h000000, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 32'hFFFF_F000, 2'd3, 3, 24'hFFFC00, 2'd2, 1'b1};
    vecs[11] = '{1'b0, 32'h1234_5678, 2'd3, 3, 24'h000000, 2'd2, 1'b0};
    fail_mdl[0] = 0;
    fail_mdl[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, ir_a}, 32'd1);
    chk("reset_out_valid", {31'b0, ov_a}, 32'd0);
    chk("reset_outputs", {5'b0, od_a, oc_a, ok_a}, 32'd0);
    chk("reset_fail_count", {24'b0, fc_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sel = vecs[i].s;
      issue(vecs[i].value, vecs[i].mode, k);
      chk($sformatf("v%0d_latency", i), 32'(k), 32'(vecs[i].lat));
      chk($sformatf("v%0d_data", i), {8'b0, od}, {8'b0, vecs[i].data});
      chk($sformatf("v%0d_control", i), {30'b0, oc}, {30'b0, vecs[i].ctrl});
      chk($sformatf("v%0d_ok", i), {31'b0, ok}, {31'b0, vecs[i].ok});
      chk($sformatf("v%0d_in_ready_busy", i), {31'b0, ir}, 32'd0);
      handoff(vecs[i].ok);
    end
    // stall in DONE with a competing request that must be ignored
    sel = 1'b0;
    issue(32'h0000_0033, 2'd0, k);
    @(negedge clk);
    in_value = 32'h0000_0077;
    in_mode  = 2'd0;
    iv_a     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", {31'b0, ov_a}, 32'd1);
      chk("stall_data", {8'b0, od_a}, 32'h33);
      chk("stall_ctrl_ok", {29'b0, oc_a, ok_a}, 32'b001);
      chk("stall_in_ready", {31'b0, ir_a}, 32'd0);
    end
    iv_a = 1'b0;
    handoff(1'b1);
    // the ignored request must not appear later
    repeat (3) @(posedge clk);
    #1;
    chk("no_ghost_request", {31'b0, ov_a}, 32'd0);
    chk("fail_count_nonzero_before_reset", {31'b0, fc_a != 8'd0}, 32'd1);
    // asynchronous reset in the middle of an auto search
    @(negedge clk);
    in_value = 32'h1234_5678;
    in_mode  = 2'd3;
    iv_a     = 1'b1;
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {5'b0, od_a, oc_a, ok_a}, 32'd0);
    chk("async_rst_out_valid", {31'b0, ov_a}, 32'd0);
    chk("async_rst_in_ready", {31'b0, ir_a}, 32'd1);
    chk("async_rst_fail_count", {24'b0, fc_a}, 32'd0);
    fail_mdl[0] = 0;
    fail_mdl[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_out_valid", {31'b0, ov_a}, 32'd0);
    chk("post_rst_in_ready", {31'b0, ir_a}, 32'd1);
    issue(32'h0000_0FFF, 2'd3, k);
    chk("post_rst_latency", 32'(k), 32'd2);
    chk("post_rst_data", {8'b0, od_a}, 32'h000FFF);
    handoff(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
